// File: rtl/debug_loader.sv
// Framed byte-stream program loader: parses SYNC/ADDR/COUNT/DATA frames and drives the
// core's debug instruction-write port, holding the core in reset while a load runs.
module debug_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         CNT_W     = 16,
  parameter int         TIMEOUT   = 50000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        DEBUG_SIG,
  output logic [31:0] DEBUG_addr,
  output logic [31:0] DEBUG_instr,
  output logic        debug_we,
  output logic        core_nrst,
  output logic        load_done,
  output logic        load_err
);

  localparam int NB = CNT_W / 8;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ADDR, CNT, DATA, WRITE, DONE, ERR} state_t;

  state_t           state, state_nx;
  logic [7:0]       bcnt;
  logic [TW-1:0]    timer;
  logic [31:0]      addr, word;
  logic [CNT_W-1:0] rem;
  logic [31:0]      addr_full, word_full;
  logic [CNT_W-1:0] cnt_full;
  logic             acc, tmo;

  assign byte_ready = (state == IDLE) || (state == ADDR) || (state == CNT) || (state == DATA);
  assign debug_we   = (state == WRITE);
  assign load_done  = (state == DONE);
  assign load_err   = (state == ERR);

  assign acc = byte_valid & byte_ready;
  assign tmo = (timer == TW'(TIMEOUT - 1));

  // Fields arrive LE, so each byte shifts in from the top; the value is complete on the last byte.
  assign addr_full = {byte_data, addr[31:8]};
  assign word_full = {byte_data, word[31:8]};
  assign cnt_full  = (rem >> 8) | (CNT_W'(byte_data) << (CNT_W - 8));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (acc && byte_data == SYNC_BYTE) state_nx = ADDR;
      ADDR: begin
        if (acc) begin
          if (bcnt == 8'd3) state_nx = (addr_full[1:0] != 2'b00) ? ERR : CNT;
        end else if (tmo) state_nx = ERR;
      end
      CNT: begin
        if (acc) begin
          if (bcnt == 8'(NB - 1)) state_nx = (cnt_full == '0) ? DONE : DATA;
        end else if (tmo) state_nx = ERR;
      end
      DATA: begin
        if (acc) begin
          if (bcnt == 8'd3) state_nx = WRITE;
        end else if (tmo) state_nx = ERR;
      end
      WRITE:   state_nx = (rem > CNT_W'(1)) ? DATA : DONE;
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      bcnt        <= '0;
      timer       <= '0;
      addr        <= '0;
      word        <= '0;
      rem         <= '0;
      DEBUG_SIG   <= 1'b0;
      DEBUG_addr  <= '0;
      DEBUG_instr <= '0;
      core_nrst   <= 1'b1;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (acc && byte_data == SYNC_BYTE) begin
            DEBUG_SIG <= 1'b1;
            core_nrst <= 1'b0;
          end
        end
        ADDR, CNT, DATA: begin
          if (acc) begin
            bcnt  <= bcnt + 8'd1;
            timer <= '0;
            if (state == ADDR) addr <= addr_full;
            if (state == CNT)  rem  <= cnt_full;
            if (state == DATA) word <= word_full;
            if (state == DATA && bcnt == 8'd3) begin
              DEBUG_addr  <= addr;
              DEBUG_instr <= word_full;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WRITE: begin
          addr <= addr + 32'd4;
          rem  <= rem - CNT_W'(1);
        end
        DONE: begin
          DEBUG_SIG <= 1'b0;
          core_nrst <= 1'b1;
        end
        // core_nrst deliberately left low: the image in memory is incomplete.
        ERR:     DEBUG_SIG <= 1'b0;
        default: ;
      endcase
      if (state_nx != state) begin
        bcnt  <= '0;
        timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_debug_loader.sv
// Randomized + directed bench for debug_loader against a frame-position reference model.
module tb_debug_loader;
  localparam int TMO = 30;
  localparam int NB  = 2;
  localparam int PW = 1, PD = 2, PE = 3;

  logic        clk = 1'b0, nrst = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, DEBUG_SIG, debug_we, core_nrst, load_done, load_err;
  logic [31:0] DEBUG_addr, DEBUG_instr;

  always #5 clk = ~clk;

  debug_loader #(.SYNC_BYTE(8'hA5), .CNT_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .DEBUG_SIG(DEBUG_SIG), .DEBUG_addr(DEBUG_addr),
    .DEBUG_instr(DEBUG_instr), .debug_we(debug_we), .core_nrst(core_nrst),
    .load_done(load_done), .load_err(load_err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks byte position inside the frame and a queue of
  // one-cycle pulses (write/done/err) that the frame has owed the outputs.
  bit          started = 0, m_frame = 0;
  int          m_pos, m_idle;
  int unsigned m_rem;
  logic [31:0] m_addr, m_waddr, m_word, m_eaddr = 0, m_einstr = 0;
  logic        m_sig = 0, m_cn = 1;
  int          pend[$];

  task automatic take(input logic [7:0] b);
    int k;
    if (m_pos <= 4) begin
      m_addr[8*(m_pos-1) +: 8] = b;
      if (m_pos == 4) begin
        m_waddr = m_addr;
        if (m_addr[1:0] != 2'b00) begin pend.push_back(PE); m_frame = 0; end
      end
    end else if (m_pos <= 4 + NB) begin
      if (m_pos == 5) m_rem = 0;
      m_rem += int'(b) << (8 * (m_pos - 5));
      if (m_pos == 4 + NB && m_rem == 0) begin pend.push_back(PD); m_frame = 0; end
    end else begin
      k = (m_pos - 5 - NB) % 4;
      m_word[8*k +: 8] = b;
      if (k == 3) begin
        pend.push_back(PW);
        m_eaddr  = m_waddr;
        m_einstr = m_word;
        if (m_rem == 1) begin pend.push_back(PD); m_frame = 0; end
      end
    end
  endtask

  always @(posedge clk) begin
    int p;
    started = 1;
    if (!nrst) begin
      m_frame = 0; pend.delete(); m_sig = 0; m_cn = 1; m_eaddr = 0; m_einstr = 0;
    end else if (pend.size() > 0) begin
      p = pend.pop_front();
      if (p == PW) begin m_waddr += 32'd4; m_rem--; m_idle = 0; end
      if (p == PD) begin m_sig = 0; m_cn = 1; end
      if (p == PE) m_sig = 0;
    end else if (m_frame) begin
      if (byte_valid) begin m_idle = 0; m_pos++; take(byte_data); end
      else begin
        m_idle++;
        if (m_idle == TMO) begin pend.push_back(PE); m_frame = 0; end
      end
    end else if (byte_valid && byte_data == 8'hA5) begin
      m_frame = 1; m_pos = 0; m_idle = 0; m_sig = 1; m_cn = 0;
    end
  end

  logic [31:0] wl_a[$], wl_d[$];
  int n_done = 0, n_err = 0;

  always @(negedge clk) begin
    int f;
    if (started) begin
      f = (pend.size() > 0) ? pend[0] : 0;
      chk("byte_ready", byte_ready, pend.size() == 0);
      chk("debug_we",   debug_we,   f == PW);
      chk("load_done",  load_done,  f == PD);
      chk("load_err",   load_err,   f == PE);
      chk("DEBUG_SIG",  DEBUG_SIG,  m_sig);
      chk("core_nrst",  core_nrst,  m_cn);
      chk("DEBUG_addr", DEBUG_addr, m_eaddr);
      chk("DEBUG_instr", DEBUG_instr, m_einstr);
      if (debug_we === 1'b1) begin wl_a.push_back(DEBUG_addr); wl_d.push_back(DEBUG_instr); end
      if (load_done === 1'b1) n_done++;
      if (load_err === 1'b1) n_err++;
    end
  end

  task automatic send(input logic [7:0] b);
    logic r;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk) r = byte_ready;
      @(posedge clk); #1;
      if (r) return;
    end
    checks++; errors++;
    $display("FAIL send_timeout: byte %h not accepted within 200 cycles", b);
  endtask

  task automatic gap(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] fb[$];

  task automatic push_le(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) fb.push_back(v[8*i +: 8]);
  endtask

  task automatic build(input logic [31:0] a, input int cnt);
    fb.delete();
    fb.push_back(8'hA5);
    push_le(a, 4);
    push_le(cnt, NB);
    for (int i = 0; i < cnt; i++) push_le($urandom, 4);
  endtask

  task automatic run_fb(input int gmax);
    foreach (fb[i]) begin
      send(fb[i]);
      if (gmax > 0 && $urandom_range(0, 1) == 1) gap($urandom_range(1, gmax));
    end
    gap(8);
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  initial begin
    int nw, nd, ne;
    logic [7:0] g;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", byte_ready, 1'b1);
    chk("rst_sig", DEBUG_SIG, 1'b0);
    chk("rst_core_nrst", core_nrst, 1'b1);
    chk("rst_we", debug_we, 1'b0);
    chk("rst_addr", DEBUG_addr, 32'h0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // 1: basic two-word load
    fb = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00,
           8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_fb(2);
    chk("t1_nwrites", wl_a.size(), 2);
    chk("t1_a0", wl_a[0], 32'h0000_1000);
    chk("t1_d0", wl_d[0], 32'h0000_0013);
    chk("t1_a1", wl_a[1], 32'h0000_1004);
    chk("t1_d1", wl_d[1], 32'h0010_0093);
    chk("t1_done", n_done, 1);
    chk("t1_core_nrst", core_nrst, 1'b1);

    // 2: garbage before sync
    send(8'h00); send(8'hFF); gap(3);
    chk("t2_sig_before_sync", DEBUG_SIG, 1'b0);
    nw = wl_a.size();
    fb = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_fb(1);
    chk("t2_nwrites", wl_a.size() - nw, 1);
    chk("t2_a", wl_a[nw], 32'h0000_2000);
    chk("t2_d", wl_d[nw], 32'hDEAD_BEEF);

    // 3: address wrap
    nw = wl_a.size();
    build(32'hFFFF_FFFC, 2);
    run_fb(0);
    chk("t3_a0", wl_a[nw], 32'hFFFF_FFFC);
    chk("t3_a1", wl_a[nw+1], 32'h0000_0000);

    // 4: misaligned base address
    nw = wl_a.size(); ne = n_err;
    fb = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00};
    run_fb(0);
    chk("t4_err", n_err - ne, 1);
    chk("t4_core_nrst", core_nrst, 1'b0);
    chk("t4_nwrites", wl_a.size() - nw, 0);

    // 5: stall inside the data field, then recover
    ne = n_err;
    build(32'h0000_0100, 2);
    for (int i = 0; i < 9; i++) send(fb[i]);
    gap(TMO + 5);
    chk("t5_err", n_err - ne, 1);
    chk("t5_nwrites", wl_a.size() - nw, 0);
    chk("t5_core_nrst_held", core_nrst, 1'b0);
    build(32'h0000_0200, 1);
    run_fb(2);
    chk("t5_recover_core_nrst", core_nrst, 1'b1);

    // 6: zero-count frame
    nw = wl_a.size(); nd = n_done;
    build(32'h0000_0300, 0);
    run_fb(0);
    chk("t6_done", n_done - nd, 1);
    chk("t6_nwrites", wl_a.size() - nw, 0);

    // 7: reset in the middle of the data field
    fb = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00};
    run_fb(0);
    build(32'h0000_0400, 3);
    for (int i = 0; i < 13; i++) send(fb[i]);
    do_reset();
    @(negedge clk);
    chk("t7_sig", DEBUG_SIG, 1'b0);
    chk("t7_core_nrst", core_nrst, 1'b1);
    chk("t7_addr", DEBUG_addr, 32'h0);
    chk("t7_instr", DEBUG_instr, 32'h0);
    gap(2);

    // 8: byte_valid held high through the whole frame
    nw = wl_a.size();
    build(32'h0000_0800, 4);
    run_fb(0);
    chk("t8_nwrites", wl_a.size() - nw, 4);
    chk("t8_last_addr", wl_a[nw+3], 32'h0000_080C);

    // randomized frames
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < $urandom_range(0, 2); i++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send(g);
      end
      build(($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC), $urandom_range(0, 4));
      case ($urandom_range(0, 9))
        0: begin
          for (int i = 0; i < $urandom_range(1, fb.size() - 1); i++) send(fb[i]);
          gap(TMO + 3);
        end
        1: begin
          for (int i = 0; i < $urandom_range(1, fb.size() - 1); i++) send(fb[i]);
          do_reset();
          gap(2);
        end
        default: run_fb($urandom_range(0, 3));
      endcase
    end
    gap(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
